mmio_peripherals: RTL and testbench

Memory-mapped peripheral block on the data-memory side of the pipelined CPU. It decodes the EX/MEM-stage data address alongside the data memory and holds these registers:
- a reloadable 32-bit timer that can raise an interrupt;
- a free-running system tick counter;
- an LED output register;
- a 7-segment display output register.

The top level selects `ReadData` over data-memory output whenever `Hit` is high. The result feeds the MEM/WB write-back mux.

---
 rtl/mmio_peripherals.sv | 113 +++++++++++
 tb/tb_mmio_peripherals.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_peripherals.sv
// Memory-mapped timer, systick, LED and 7-segment registers on the CPU data-memory side.
// Reads are combinational; writes and timer/tick updates land on the rising edge.
module mmio_peripherals #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        IRQ,
   output logic [7:0]  leds,
   output logic [11:0] digi
);

   localparam logic [2:0] OFF_TH   = 3'd0;
   localparam logic [2:0] OFF_TL   = 3'd1;
   localparam logic [2:0] OFF_TCON = 3'd2;
   localparam logic [2:0] OFF_LEDS = 3'd3;
   localparam logic [2:0] OFF_DIGI = 3'd4;
   localparam logic [2:0] OFF_TICK = 3'd5;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [7:0]  leds_q, leds_d;
   logic [11:0] digi_q, digi_d;
   logic [31:0] systick_q, systick_d;

   logic [31:0] offs;
   logic [2:0]  word_off;
   logic        wr_en;
   logic        ovf;
   logic        irq_set;

   // Unsigned subtraction makes addresses below the base wrap high, so one compare bounds both ends.
   assign offs     = Address - BASE_ADDR;
   assign Hit      = (offs < 32'd24);
   assign word_off = offs[4:2];
   assign wr_en    = MemWrite && Hit;

   assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
   assign irq_set = ovf && tcon_q[1];

   always_comb begin
      ReadData = 32'h0;
      if (MemRead && Hit) begin
         case (word_off)
            OFF_TH:   ReadData = th_q;
            OFF_TL:   ReadData = tl_q;
            OFF_TCON: ReadData = {29'h0, tcon_q};
            OFF_LEDS: ReadData = {24'h0, leds_q};
            OFF_DIGI: ReadData = {20'h0, digi_q};
            OFF_TICK: ReadData = systick_q;
            default:  ReadData = 32'h0;
         endcase
      end
   end

   always_comb begin
      th_d      = th_q;
      tl_d      = tl_q;
      tcon_d    = tcon_q;
      leds_d    = leds_q;
      digi_d    = digi_q;
      systick_d = systick_q + 32'd1;

      if (tcon_q[0]) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end
      if (irq_set) begin
         tcon_d[2] = 1'b1;
      end

      // Software writes override the timer, except that a same-edge overflow still sets status.
      if (wr_en) begin
         case (word_off)
            OFF_TH:   th_d   = WriteData;
            OFF_TL:   tl_d   = WriteData;
            OFF_TCON: tcon_d = {WriteData[2] | irq_set, WriteData[1:0]};
            OFF_LEDS: leds_d = WriteData[7:0];
            OFF_DIGI: digi_d = WriteData[11:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q      <= 32'h0;
         tl_q      <= 32'h0;
         tcon_q    <= 3'h0;
         leds_q    <= 8'h0;
         digi_q    <= 12'h0;
         systick_q <= 32'h0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         leds_q    <= leds_d;
         digi_q    <= digi_d;
         systick_q <= systick_d;
      end
   end

   assign IRQ  = tcon_q[2];
   assign leds = leds_q;
   assign digi = digi_q;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Directed bench for mmio_peripherals: stimulus pushes expected responses, a negedge monitor checks them.
module tb_mmio_peripherals;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        Hit;
   logic        IRQ;
   logic [7:0]  leds;
   logic [11:0] digi;

   always #5 clk = ~clk;

   mmio_peripherals #(.BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .IRQ       (IRQ),
      .leds      (leds),
      .digi      (digi)
   );

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        hit;
      bit          chk;
      logic        irq;
      logic [7:0]  leds;
      logic [11:0] digi;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   m_chk = 1'b0;
   logic       m_irq  = 1'b0;
   logic [7:0] m_leds = 8'h0;
   logic [11:0] m_digi = 12'h0;
   bit   end_req = 1'b0;
   bit   end_ack = 1'b0;

   function automatic void cmp(input string name, input string what,
                               input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s got=%h want=%h", name, what, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (MemRead || MemWrite) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn got=1 want=0");
         end else begin
            e = sb.pop_front();
            cmp(e.name, "ReadData", ReadData, e.rd);
            cmp(e.name, "Hit", {31'h0, Hit}, {31'h0, e.hit});
            if (e.chk) begin
               cmp(e.name, "IRQ", {31'h0, IRQ}, {31'h0, e.irq});
               cmp(e.name, "leds", {24'h0, leds}, {24'h0, e.leds});
               cmp(e.name, "digi", {20'h0, digi}, {20'h0, e.digi});
            end
         end
      end
      if (end_req && !end_ack) begin
         total++;
         if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
         end
         end_ack = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_hit, input string name);
      exp_t e;
      Address   = addr;
      WriteData = wdata;
      MemWrite  = wr;
      MemRead   = !wr;
      e.name = name;
      e.rd   = exp_rd;
      e.hit  = exp_hit;
      e.chk  = m_chk;
      e.irq  = m_irq;
      e.leds = m_leds;
      e.digi = m_digi;
      sb.push_back(e);
      tick();
      MemWrite = 1'b0;
      MemRead  = 1'b0;
   endtask

   task automatic rd(input int off, input logic [31:0] exp, input string name);
      xact(1'b0, BASE + 32'(off * 4), 32'h0, exp, 1'b1, name);
   endtask

   task automatic wr(input int off, input logic [31:0] data, input string name);
      xact(1'b1, BASE + 32'(off * 4), data, 32'h0, 1'b1, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; Address = 32'h0; WriteData = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;

      // Dirty state, then an asynchronous reset between edges.
      wr(3, 32'hFF, "pre_leds");
      wr(4, 32'hABC, "pre_digi");
      wr(0, 32'h55, "pre_th");
      wr(2, 32'h7, "pre_tcon");
      tick();
      reset = 1'b1;
      m_chk = 1'b1; m_irq = 1'b0; m_leds = 8'h0; m_digi = 12'h0;
      rd(3, 32'h0, "rst_async_leds");
      reset = 1'b0;
      cyc = 0;
      rd(5, 32'(cyc), "rst_systick");
      rd(0, 32'h0, "rst_th");
      rd(1, 32'h0, "rst_tl");
      rd(2, 32'h0, "rst_tcon");
      rd(3, 32'h0, "rst_leds");
      rd(4, 32'h0, "rst_digi");

      // Decode edges of the window.
      xact(1'b0, BASE + 32'h18, 32'h0, 32'h0, 1'b0, "miss_rd_18");
      xact(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 32'h0, 1'b0, "miss_wr_18");
      xact(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b0, "miss_wr_20");
      xact(1'b1, BASE - 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b0, "miss_wr_below");
      xact(1'b0, BASE - 32'h4, 32'h0, 32'h0, 1'b0, "miss_rd_below");
      xact(1'b0, BASE + 32'h17, 32'h0, 32'(cyc), 1'b1, "hit_rd_17");
      rd(0, 32'h0, "miss_kept_th");
      rd(1, 32'h0, "miss_kept_tl");
      rd(2, 32'h0, "miss_kept_tcon");
      rd(3, 32'h0, "miss_kept_leds");
      rd(4, 32'h0, "miss_kept_digi");

      // Plain register read/write and width truncation.
      wr(3, 32'h1234_56A5, "wr_leds");
      m_leds = 8'hA5;
      rd(3, 32'hA5, "rd_leds");
      wr(4, 32'hFFFF_F3C6, "wr_digi");
      m_digi = 12'h3C6;
      rd(4, 32'h3C6, "rd_digi");
      xact(1'b0, BASE + 32'hF, 32'h0, 32'hA5, 1'b1, "rd_leds_byte3");
      wr(2, 32'hFFFF_FFF8, "wr_tcon_f8");
      rd(2, 32'h0, "rd_tcon_f8");
      wr(2, 32'hFFFF_FFFC, "wr_tcon_fc");
      m_irq = 1'b1;
      rd(2, 32'h4, "rd_tcon_fc");
      wr(2, 32'h0, "clr_tcon");
      m_irq = 1'b0;

      // Reload sequence with interrupts enabled.
      wr(0, 32'hFFFF_FFFD, "wr_th");
      wr(1, 32'hFFFF_FFFD, "wr_tl");
      wr(2, 32'h3, "wr_tcon_en");
      rd(1, 32'hFFFF_FFFD, "tl_start");
      rd(1, 32'hFFFF_FFFE, "tl_inc1");
      rd(1, 32'hFFFF_FFFF, "tl_inc2");
      m_irq = 1'b1;
      rd(1, 32'hFFFF_FFFD, "tl_reload");
      wr(2, 32'h1, "wr_tcon_ie0");
      m_irq = 1'b0;
      rd(1, 32'hFFFF_FFFF, "tl_ie0_max");
      rd(1, 32'hFFFF_FFFD, "tl_ie0_reload");
      rd(1, 32'hFFFF_FFFE, "tl_ie0_inc");
      rd(2, 32'h1, "tcon_ie0");

      // Software writes colliding with an overflow.
      wr(2, 32'h0, "stop1");
      wr(1, 32'hFFFF_FFFF, "tl_max");
      wr(2, 32'h7, "tcon_7");
      m_irq = 1'b1;
      wr(2, 32'h3, "tcon_clr_on_ovf");
      rd(2, 32'h7, "tcon_collide");
      wr(2, 32'h3, "tcon_clr");
      m_irq = 1'b0;
      wr(1, 32'h5, "tl_wr_on_ovf");
      m_irq = 1'b1;
      rd(1, 32'h5, "tl_wr_wins");
      rd(2, 32'h7, "tcon_ovf_set");
      wr(2, 32'h0, "stop2");
      m_irq = 1'b0;
      rd(1, 32'h8, "tl_stopped");
      rd(1, 32'h8, "tl_held");
      rd(0, 32'hFFFF_FFFD, "th_readback");

      // systick spacing and write immunity.
      rd(5, 32'(cyc), "tick_a");
      repeat (9) tick();
      rd(5, 32'(cyc), "tick_b");
      wr(5, 32'h0, "tick_wr");
      rd(5, 32'(cyc), "tick_after_wr");
      rd(3, 32'hA5, "leds_after_tick_wr");
      rd(4, 32'h3C6, "digi_after_tick_wr");

      repeat (2) tick();
      end_req = 1'b1;
      for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
      if (!end_ack) begin
         $display("FAIL end_ack got=0 want=1");
         $fatal(1, "monitor did not acknowledge");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
